// File: rtl/button_debounce_bank.sv
// N_CH-channel push-button conditioner: 2-flop sync, per-channel debounce, press/release pulses, long-hold flag.
// Optional auto-repeat of btn_press while held long is compiled in with `define BTN_AUTO_REPEAT_EN.
module button_debounce_bank #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES   = 64,
    parameter int unsigned REPEAT_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] long_hold
);

    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        REL  = 2'd0,
        PRS  = 2'd1,
        LONG = 2'd2
    } state_e;

    logic [N_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic [SW-1:0] stab_cnt_q, stab_cnt_d;
            logic [HW-1:0] hold_cnt_q, hold_cnt_d;
            logic          level_q, level_d;
            logic          press_q, press_d;
            logic          release_q, release_d;
            logic          long_q, long_d;
            logic          rise, fall;
            state_e        state_q, state_d;
`ifdef BTN_AUTO_REPEAT_EN
            logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

            always_comb begin
                stab_cnt_d = '0;
                level_d    = level_q;
                press_d    = 1'b0;
                release_d  = 1'b0;
                rise       = 1'b0;
                fall       = 1'b0;
                state_d    = state_q;
                hold_cnt_d = hold_cnt_q;
`ifdef BTN_AUTO_REPEAT_EN
                rep_cnt_d  = '0;
`endif
                // Any sample that matches the current level leaves stab_cnt_d at zero.
                if (sync2_q[i] != level_q) begin
                    if (stab_cnt_q == SW'(STABLE_CYCLES - 1)) begin
                        level_d   = sync2_q[i];
                        press_d   = sync2_q[i];
                        release_d = ~sync2_q[i];
                        rise      = sync2_q[i];
                        fall      = ~sync2_q[i];
                    end else begin
                        stab_cnt_d = stab_cnt_q + 1'b1;
                    end
                end

                case (state_q)
                    REL: begin
                        if (rise) begin
                            state_d    = PRS;
                            hold_cnt_d = '0;
                        end
                    end
                    PRS: begin
                        if (fall) begin
                            state_d = REL;
                        end else if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                            state_d = LONG;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    LONG: begin
                        if (fall) begin
                            state_d = REL;
                        end
                    end
                    default: state_d = REL;
                endcase

`ifdef BTN_AUTO_REPEAT_EN
                // Repeat counter only runs on cycles spent wholly inside LONG.
                if (state_q == LONG && state_d == LONG) begin
                    if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                        press_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
`endif
                long_d = (state_d == LONG);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stab_cnt_q <= '0;
                    hold_cnt_q <= '0;
                    level_q    <= 1'b0;
                    press_q    <= 1'b0;
                    release_q  <= 1'b0;
                    long_q     <= 1'b0;
                    state_q    <= REL;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_cnt_q  <= '0;
`endif
                end else begin
                    stab_cnt_q <= stab_cnt_d;
                    hold_cnt_q <= hold_cnt_d;
                    level_q    <= level_d;
                    press_q    <= press_d;
                    release_q  <= release_d;
                    long_q     <= long_d;
                    state_q    <= state_d;
`ifdef BTN_AUTO_REPEAT_EN
                    rep_cnt_q  <= rep_cnt_d;
`endif
                end
            end

            assign btn_level[i]   = level_q;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = release_q;
            assign long_hold[i]   = long_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench for button_debounce_bank: stimulus queues expected output events,
// a monitor pops and compares one entry on every cycle with a pulse or long_hold change.
module tb_button_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_level, btn_press, btn_release, long_hold;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int       cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
        logic [3:0] lng;
    } ev_t;

    ev_t expQ[$];

    button_debounce_bank #(
        .N_CH(4), .STABLE_CYCLES(16), .LONG_CYCLES(64), .REPEAT_CYCLES(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .long_hold(long_hold)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEvent(input int c, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] l, input logic [3:0] g);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lvl = l; e.lng = g;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int holdCycles);
        btn_raw = v;
        repeat (holdCycles) @(negedge clk);
    endtask

    // Monitor: counts rising edges and checks outputs 1 time unit after each.
    initial begin
        logic [3:0] prevLong;
        ev_t e;
        prevLong = 4'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if ((|btn_press) || (|btn_release) || (long_hold !== prevLong)) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_event: press=%b release=%b level=%b long=%b, want no event (cycle %0d)",
                             btn_press, btn_release, btn_level, long_hold, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ev_cycle", cyc, e.cyc);
                    checkOutput("ev_press", btn_press, e.press);
                    checkOutput("ev_release", btn_release, e.rel);
                    checkOutput("ev_level", btn_level, e.lvl);
                    checkOutput("ev_long", long_hold, e.lng);
                end
            end
            prevLong = long_hold;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        // Reset held with all buttons pressed.
        rst_n   = 1'b0;
        btn_raw = 4'hF;
        repeat (5) @(negedge clk);
        checkOutput("rst_level", btn_level, 4'h0);
        checkOutput("rst_press", btn_press, 4'h0);
        checkOutput("rst_release", btn_release, 4'h0);
        checkOutput("rst_long", long_hold, 4'h0);
        rst_n   = 1'b1;
        btn_raw = 4'h0;
        @(negedge clk);
        checkOutput("post_rst_level", btn_level, 4'h0);
        checkOutput("post_rst_press", btn_press, 4'h0);
        checkOutput("post_rst_release", btn_release, 4'h0);
        checkOutput("post_rst_long", long_hold, 4'h0);
        repeat (5) @(negedge clk);

        // Mid-count reset on ch0, then clean press 18 edges after release of reset.
        applyStimulus(4'b0001, 10);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_level", btn_level, 4'h0);
        checkOutput("midrst_press", btn_press, 4'h0);
        rst_n = 1'b1;
        pushEvent(cyc + 18, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        repeat (30) @(negedge clk);
        checkOutput("ch0_level_held", btn_level, 4'b0001);

        // Short release on ch0: single release pulse, no long_hold.
        pushEvent(cyc + 18, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 30);

        // Bounce on ch1: high bursts of 5, 3 and 10 cycles, then a steady press.
        applyStimulus(4'b0010, 5);
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0010, 3);
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0010, 10);
        applyStimulus(4'b0000, 2);
        checkOutput("bounce_level", btn_level, 4'h0);
        pushEvent(cyc + 18, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 25);
        pushEvent(cyc + 18, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 30);

        // Long press on ch2 held for 200 cycles.
        c = cyc;
        pushEvent(c + 18, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        pushEvent(c + 82, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`ifdef BTN_AUTO_REPEAT_EN
        pushEvent(c + 114, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        pushEvent(c + 146, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        pushEvent(c + 178, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        pushEvent(c + 210, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
`endif
        pushEvent(c + 218, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        applyStimulus(4'b0100, 200);
        applyStimulus(4'b0000, 40);

        // All four channels at once, then ch3 released alone.
        c = cyc;
        pushEvent(c + 18, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        pushEvent(c + 43, 4'b0000, 4'b1000, 4'b0111, 4'b0000);
        pushEvent(c + 48, 4'b0000, 4'b0111, 4'b0000, 4'b0000);
        applyStimulus(4'b1111, 25);
        applyStimulus(4'b0111, 5);
        applyStimulus(4'b0000, 40);

        checkOutput("pending_events", expQ.size(), 0);
        checkOutput("final_level", btn_level, 4'h0);
        checkOutput("final_long", long_hold, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
